lcd_spi_streamer: RTL

//  Parametrised PCD8544 (Nokia 5110) frame streamer; successor to the fixed 6-byte controller.

---
 rtl/lcd_spi_streamer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_streamer.sv
// PCD8544 (Nokia 5110) frame streamer: LCD reset pulse, init sequence, then WORDS x BYTES data bytes per frame over SPI mode 0.
// Define LCD_ADDR_RESET_EN to send the X=0/Y=0 address commands (0x80, 0x40) before every frame.
module lcd_spi_streamer #(
    parameter int          BYTES      = 6,
    parameter int          WORDS      = 84,
    parameter int          CLK_DIV    = 6,
    parameter int          RST_CYCLES = 16,
    parameter logic [7:0]  VOP        = 8'hC0,
    parameter logic [7:0]  BIAS       = 8'h14,
    localparam int         AW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic [BYTES*8-1:0] mem_data,
    input  logic               mem_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               SCK,
    output logic               MOSI,
    output logic               DC,
    output logic               CS,
    output logic               LCD_reset
);

    localparam int BW  = ($clog2(BYTES + 1) > 3) ? $clog2(BYTES + 1) : 3;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0]  N_INIT    = BW'(6);
    localparam logic [BW-1:0]  N_DATA    = BW'(BYTES);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(WORDS - 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
`ifdef LCD_ADDR_RESET_EN
    localparam logic [BW-1:0]  N_ADDR    = BW'(2);
`endif

    typedef enum logic [2:0] {
        S_LCDRST, S_INIT, S_IDLE, S_ADDR, S_FETCH, S_SHIFT, S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [RCW-1:0]     rst_cnt_q;
    logic               lcd_rst_q;
    logic [BW-1:0]      bidx_q;
    logic [BYTES*8-1:0] word_q;
    logic [AW-1:0]      addr_q;

    logic               act_q, cs_q, sck_q, mosi_q, dc_q;
    logic [7:0]         sh_q;
    logic [4:0]         hcnt_q;
    logic [DW-1:0]      div_q;

    logic               sending, tx_dc, byte_last, byte_start;
    logic [7:0]         tx_byte;
    logic [BW-1:0]      n_bytes;

    // Half-period 16 is the CS-high tail; its final clk may launch the next byte.
    assign byte_last  = act_q && (hcnt_q == 5'd16) && (div_q == DIV_LAST);
    assign byte_start = sending && ((!act_q && bidx_q == '0) || (byte_last && bidx_q < n_bytes));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_LCDRST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LCDRST: if (rst_cnt_q == RST_LAST) state_d = S_INIT;
            S_INIT:   if (byte_last && bidx_q == N_INIT) state_d = S_IDLE;
            S_IDLE: begin
                if (enable) begin
`ifdef LCD_ADDR_RESET_EN
                    state_d = S_ADDR;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef LCD_ADDR_RESET_EN
            S_ADDR:   if (byte_last && bidx_q == N_ADDR) state_d = S_FETCH;
`endif
            S_FETCH:  if (mem_valid) state_d = S_SHIFT;
            S_SHIFT:  if (byte_last && bidx_q == N_DATA) state_d = S_NEXT;
            S_NEXT:   state_d = (addr_q == LAST_ADDR) ? S_IDLE : S_FETCH;
            default:  state_d = S_LCDRST;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        mem_req    = (state_q == S_FETCH);
        frame_done = (state_q == S_NEXT) && (addr_q == LAST_ADDR);
    end

    always_comb begin
        sending = 1'b0;
        tx_dc   = 1'b1;
        n_bytes = N_DATA;
        tx_byte = word_q[BYTES*8-1 -: 8];
        case (state_q)
            S_INIT: begin
                sending = 1'b1;
                tx_dc   = 1'b0;
                n_bytes = N_INIT;
                case (bidx_q)
                    BW'(0):  tx_byte = 8'h21;
                    BW'(1):  tx_byte = VOP;
                    BW'(2):  tx_byte = 8'h04;
                    BW'(3):  tx_byte = BIAS;
                    BW'(4):  tx_byte = 8'h20;
                    default: tx_byte = 8'h0C;
                endcase
            end
`ifdef LCD_ADDR_RESET_EN
            S_ADDR: begin
                sending = 1'b1;
                tx_dc   = 1'b0;
                n_bytes = N_ADDR;
                tx_byte = (bidx_q == '0) ? 8'h80 : 8'h40;
            end
`endif
            S_SHIFT: sending = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_q <= '0;
            lcd_rst_q <= 1'b0;
            bidx_q    <= '0;
            word_q    <= '0;
            addr_q    <= '0;
        end else begin
            if (state_q == S_LCDRST) rst_cnt_q <= rst_cnt_q + 1'b1;
            if (state_d != S_LCDRST) lcd_rst_q <= 1'b1;
            if (state_d != state_q)  bidx_q <= '0;
            else if (byte_start)     bidx_q <= bidx_q + 1'b1;
            if (state_q == S_FETCH && mem_valid)
                word_q <= mem_data;
            else if (state_q == S_SHIFT && byte_start)
                word_q <= word_q << 8;
            if (state_q == S_NEXT)
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
    end

    // Even half-periods hold SCK low (MOSI may change), odd ones hold it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q  <= 1'b0;
            cs_q   <= 1'b1;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            dc_q   <= 1'b0;
            sh_q   <= '0;
            hcnt_q <= '0;
            div_q  <= '0;
        end else if (byte_start) begin
            act_q  <= 1'b1;
            cs_q   <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= tx_byte[7];
            dc_q   <= tx_dc;
            sh_q   <= {tx_byte[6:0], 1'b0};
            hcnt_q <= '0;
            div_q  <= '0;
        end else if (act_q) begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                hcnt_q <= hcnt_q + 5'd1;
                if (hcnt_q == 5'd16) begin
                    act_q <= 1'b0;
                end else if (!hcnt_q[0]) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q <= 1'b0;
                    if (hcnt_q == 5'd15) begin
                        cs_q <= 1'b1;
                    end else begin
                        mosi_q <= sh_q[7];
                        sh_q   <= {sh_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign SCK       = sck_q;
    assign MOSI      = mosi_q;
    assign DC        = dc_q;
    assign CS        = cs_q;
    assign LCD_reset = lcd_rst_q;

endmodule
